// File: rtl/poly_bank_arbiter_pkg.sv
// Shared definitions for the poly_bank arbiter: requester ids and default widths.
package poly_bank_arbiter_pkg;

    // Requester 0 is the load/store bus, requester 1 is the NTT/arithmetic core.
    localparam logic REQ_BUS = 1'b0;
    localparam logic REQ_NTT = 1'b1;

    // Default geometry of the coefficient bank.
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 46;

    // Round-robin choice between two simultaneous requesters: whoever did not
    // win last time goes next.
    function automatic logic rr_pick(input logic last_id);
        return ~last_id;
    endfunction

endpackage

// File: rtl/poly_bank_arbiter_rr_lock_arb2.sv
// Two-way round-robin arbiter with an optional lock that lets the current
// winner keep the grant for a burst. Grant is combinational; the last-grant
// pointer and lock owner are registered.
module rr_lock_arb2
    import poly_bank_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_0,
    input  logic req_1,
    input  logic lock_0,
    input  logic lock_1,
    output logic gnt_0,
    output logic gnt_1
);

    logic last_id;
    logic lock_active;
    logic lock_id;

    logic gnt_any;
    logic gnt_id;
    logic owner_req;
    logic gnt_lock;

    // Pick the winner: a live lock owner first, then a lone requester, then
    // round-robin when both are asking.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_id    = REQ_BUS;
        owner_req = (lock_id == REQ_NTT) ? req_1 : req_0;
        if (lock_active && owner_req) begin
            gnt_any = 1'b1;
            gnt_id  = lock_id;
        end else if (req_0 && req_1) begin
            gnt_any = 1'b1;
            gnt_id  = rr_pick(last_id);
        end else if (req_0) begin
            gnt_any = 1'b1;
            gnt_id  = REQ_BUS;
        end else if (req_1) begin
            gnt_any = 1'b1;
            gnt_id  = REQ_NTT;
        end
    end

    // Lock input that belongs to whoever won this cycle; other locks are ignored.
    always_comb begin
        gnt_lock = (gnt_id == REQ_NTT) ? lock_1 : lock_0;
    end

    // Decode the winner onto the per-requester grant lines.
    always_comb begin
        gnt_0 = gnt_any && (gnt_id == REQ_BUS);
        gnt_1 = gnt_any && (gnt_id == REQ_NTT);
    end

    // Remember the last winner and (re)establish or drop the lock owner. A
    // granted owner without its lock, or no grant at all, releases the lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_id     <= REQ_NTT;
            lock_active <= 1'b0;
            lock_id     <= REQ_BUS;
        end else if (gnt_any) begin
            last_id     <= gnt_id;
            lock_active <= gnt_lock;
            lock_id     <= gnt_id;
        end else begin
            lock_active <= 1'b0;
        end
    end

    // Never grant both requesters, and never grant without a request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(gnt_0 && gnt_1));
            assert (!(gnt_0 && !req_0) && !(gnt_1 && !req_1));
        end
    end

endmodule

// File: rtl/poly_bank_arbiter.sv
// Shares one poly_bank (1 write port, 1 registered-address read port) between
// the load/store bus and the NTT core. Read and write ports are arbitrated
// independently; read data is returned with a one-cycle-delayed valid.
module poly_bank_arbiter
    import poly_bank_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = 32,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  rd_req_0,
    input  logic                  rd_req_1,
    input  logic                  rd_lock_0,
    input  logic                  rd_lock_1,
    input  logic [ADDR_WIDTH-1:0] rd_addr_0,
    input  logic [ADDR_WIDTH-1:0] rd_addr_1,
    output logic                  rd_gnt_0,
    output logic                  rd_gnt_1,
    output logic                  rd_valid_0,
    output logic                  rd_valid_1,
    output logic [DATA_WIDTH-1:0] rd_data,

    input  logic                  wr_req_0,
    input  logic                  wr_req_1,
    input  logic                  wr_lock_0,
    input  logic                  wr_lock_1,
    input  logic [ADDR_WIDTH-1:0] wr_addr_0,
    input  logic [ADDR_WIDTH-1:0] wr_addr_1,
    input  logic [DATA_WIDTH-1:0] wr_data_0,
    input  logic [DATA_WIDTH-1:0] wr_data_1,
    output logic                  wr_gnt_0,
    output logic                  wr_gnt_1,

    output logic                  bank_wen,
    output logic [ADDR_WIDTH-1:0] bank_waddr,
    output logic [DATA_WIDTH-1:0] bank_din,
    output logic [ADDR_WIDTH-1:0] bank_raddr,
    input  logic [DATA_WIDTH-1:0] bank_dout
);

    // Read-port arbiter.
    rr_lock_arb2 u_rd_arb (
        .clk    (clk),
        .rst    (rst),
        .req_0  (rd_req_0),
        .req_1  (rd_req_1),
        .lock_0 (rd_lock_0),
        .lock_1 (rd_lock_1),
        .gnt_0  (rd_gnt_0),
        .gnt_1  (rd_gnt_1)
    );

    // Write-port arbiter, same policy, independent state.
    rr_lock_arb2 u_wr_arb (
        .clk    (clk),
        .rst    (rst),
        .req_0  (wr_req_0),
        .req_1  (wr_req_1),
        .lock_0 (wr_lock_0),
        .lock_1 (wr_lock_1),
        .gnt_0  (wr_gnt_0),
        .gnt_1  (wr_gnt_1)
    );

    // Steer the winning writer onto the bank; requester 0 values park on the
    // bus when nobody writes so the outputs never float between sources.
    always_comb begin
        bank_wen   = wr_gnt_0 | wr_gnt_1;
        bank_waddr = wr_addr_0;
        bank_din   = wr_data_0;
        if (wr_gnt_1) begin
            bank_waddr = wr_addr_1;
            bank_din   = wr_data_1;
        end
    end

    // Steer the winning reader's address onto the bank; rd_addr_0 when idle.
    always_comb begin
        bank_raddr = rd_gnt_1 ? rd_addr_1 : rd_addr_0;
    end

    // The bank registers its read address, so data for this cycle's grant
    // appears next cycle; the valid follows the grant by one edge and is
    // squashed by reset so an in-flight read never reports.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_0 <= 1'b0;
            rd_valid_1 <= 1'b0;
        end else begin
            rd_valid_0 <= rd_gnt_0;
            rd_valid_1 <= rd_gnt_1;
        end
    end

    // Bank output is shared; the valids say whose it is.
    always_comb begin
        rd_data = bank_dout;
    end

    // Depth passed to the bank has to match the address width.
    always_ff @(posedge clk) begin
        assert (DEPTH == (1 << ADDR_WIDTH));
    end

endmodule

// File: tb/tb_poly_bank_arbiter.sv
// Directed bench for poly_bank_arbiter with a behavioural write-first bank.
module tb_poly_bank_arbiter;

    localparam int AW = 5;
    localparam int DW = 46;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req_0, rd_req_1, rd_lock_0, rd_lock_1;
    logic [AW-1:0] rd_addr_0, rd_addr_1;
    logic          rd_gnt_0, rd_gnt_1, rd_valid_0, rd_valid_1;
    logic [DW-1:0] rd_data;
    logic          wr_req_0, wr_req_1, wr_lock_0, wr_lock_1;
    logic [AW-1:0] wr_addr_0, wr_addr_1;
    logic [DW-1:0] wr_data_0, wr_data_1;
    logic          wr_gnt_0, wr_gnt_1;
    logic          bank_wen;
    logic [AW-1:0] bank_waddr, bank_raddr;
    logic [DW-1:0] bank_din, bank_dout;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    poly_bank_arbiter #(.ADDR_WIDTH(AW), .DEPTH(32), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .rd_req_0(rd_req_0), .rd_req_1(rd_req_1),
        .rd_lock_0(rd_lock_0), .rd_lock_1(rd_lock_1),
        .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
        .rd_gnt_0(rd_gnt_0), .rd_gnt_1(rd_gnt_1),
        .rd_valid_0(rd_valid_0), .rd_valid_1(rd_valid_1),
        .rd_data(rd_data),
        .wr_req_0(wr_req_0), .wr_req_1(wr_req_1),
        .wr_lock_0(wr_lock_0), .wr_lock_1(wr_lock_1),
        .wr_addr_0(wr_addr_0), .wr_addr_1(wr_addr_1),
        .wr_data_0(wr_data_0), .wr_data_1(wr_data_1),
        .wr_gnt_0(wr_gnt_0), .wr_gnt_1(wr_gnt_1),
        .bank_wen(bank_wen), .bank_waddr(bank_waddr), .bank_din(bank_din),
        .bank_raddr(bank_raddr), .bank_dout(bank_dout)
    );

    // Behavioural bank: write at the edge, registered read address, write-first.
    logic [DW-1:0] mem [32];
    logic [AW-1:0] raddr_q;
    always_ff @(posedge clk) begin
        if (bank_wen) mem[bank_waddr] <= bank_din;
        raddr_q <= bank_raddr;
    end
    assign bank_dout = mem[raddr_q];

    task automatic idle_inputs();
        rd_req_0 = 0; rd_req_1 = 0; rd_lock_0 = 0; rd_lock_1 = 0;
        rd_addr_0 = '0; rd_addr_1 = '0;
        wr_req_0 = 0; wr_req_1 = 0; wr_lock_0 = 0; wr_lock_1 = 0;
        wr_addr_0 = '0; wr_addr_1 = '0; wr_data_0 = '0; wr_data_1 = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests_run++;
        if (rd_valid_0 !== 1'b0 || rd_valid_1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid: got %b%b expected 00", rd_valid_1, rd_valid_0);
        end
        tests_run++;
        if ({rd_gnt_1, rd_gnt_0, wr_gnt_1, wr_gnt_0, bank_wen} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_grants: got %b expected 00000",
                     {rd_gnt_1, rd_gnt_0, wr_gnt_1, wr_gnt_0, bank_wen});
        end
        rst = 0;
    endtask

    task automatic test_single_write_read();
        @(negedge clk);
        idle_inputs();
        wr_req_0 = 1; wr_addr_0 = 5'd3; wr_data_0 = 46'h1234;
        #1;
        tests_run++;
        if (wr_gnt_0 !== 1'b1 || bank_wen !== 1'b1 || bank_waddr !== 5'd3 || bank_din !== 46'h1234) begin
            tests_failed++;
            $display("[TB] FAIL single_write: gnt=%b wen=%b waddr=%0d din=%h expected 1 1 3 1234",
                     wr_gnt_0, bank_wen, bank_waddr, bank_din);
        end
        @(negedge clk);
        idle_inputs();
        rd_req_0 = 1; rd_addr_0 = 5'd3;
        #1;
        tests_run++;
        if (rd_gnt_0 !== 1'b1 || bank_raddr !== 5'd3) begin
            tests_failed++;
            $display("[TB] FAIL single_read_gnt: gnt=%b raddr=%0d expected 1 3", rd_gnt_0, bank_raddr);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (rd_valid_0 !== 1'b1 || rd_valid_1 !== 1'b0 || rd_data !== 46'h1234) begin
            tests_failed++;
            $display("[TB] FAIL single_read_data: valid=%b%b data=%h expected 01 1234",
                     rd_valid_1, rd_valid_0, rd_data);
        end
    endtask

    task automatic test_rd_round_robin();
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle_inputs();
            if (i < 4) begin
                rd_req_0 = 1; rd_req_1 = 1;
                rd_addr_0 = 5'd3; rd_addr_1 = 5'd3;
            end
            #1;
            if (i < 4) begin
                tests_run++;
                if (rd_gnt_0 !== (i % 2 == 0) || rd_gnt_1 !== (i % 2 == 1)) begin
                    tests_failed++;
                    $display("[TB] FAIL rr_gnt[%0d]: got %b%b expected %b%b", i,
                             rd_gnt_1, rd_gnt_0, (i % 2 == 1), (i % 2 == 0));
                end
            end
            if (i > 0) begin
                tests_run++;
                if (rd_valid_0 !== ((i - 1) % 2 == 0) || rd_valid_1 !== ((i - 1) % 2 == 1)) begin
                    tests_failed++;
                    $display("[TB] FAIL rr_valid[%0d]: got %b%b expected %b%b", i,
                             rd_valid_1, rd_valid_0, ((i - 1) % 2 == 1), ((i - 1) % 2 == 0));
                end
            end
        end
    endtask

    task automatic test_lock_burst();
        // A lone bus read leaves requester 0 as last winner, so the NTT side wins the conflict.
        @(negedge clk);
        idle_inputs();
        rd_req_0 = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rd_req_0 = 1; rd_req_1 = 1; rd_lock_1 = 1;
            #1;
            tests_run++;
            if (rd_gnt_1 !== 1'b1 || rd_gnt_0 !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL lock_burst[%0d]: got %b%b expected 10", i, rd_gnt_1, rd_gnt_0);
            end
        end
        @(negedge clk);
        rd_req_1 = 0; rd_lock_1 = 0;
        #1;
        tests_run++;
        if (rd_gnt_0 !== 1'b1 || rd_gnt_1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL lock_release: got %b%b expected 01", rd_gnt_1, rd_gnt_0);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_same_cycle_raw();
        @(negedge clk);
        idle_inputs();
        wr_req_1 = 1; wr_addr_1 = 5'd7; wr_data_1 = 46'h3FFF_FFFF_FFFF;
        rd_req_0 = 1; rd_addr_0 = 5'd7;
        #1;
        tests_run++;
        if (wr_gnt_1 !== 1'b1 || rd_gnt_0 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL raw_gnt: wr_gnt_1=%b rd_gnt_0=%b expected 1 1", wr_gnt_1, rd_gnt_0);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests_run++;
        if (rd_valid_0 !== 1'b1 || rd_data !== 46'h3FFF_FFFF_FFFF) begin
            tests_failed++;
            $display("[TB] FAIL raw_data: valid=%b data=%h expected 1 3fffffffffff", rd_valid_0, rd_data);
        end
    endtask

    task automatic test_concurrent_ports();
        @(negedge clk);
        idle_inputs();
        wr_addr_0 = 5'd1; wr_data_0 = 46'h5;
        wr_req_1 = 1; wr_addr_1 = 5'd9; wr_data_1 = 46'h0ABC;
        rd_req_0 = 1; rd_addr_0 = 5'd12; rd_addr_1 = 5'd20;
        #1;
        tests_run++;
        if (wr_gnt_1 !== 1'b1 || wr_gnt_0 !== 1'b0 || rd_gnt_0 !== 1'b1 || rd_gnt_1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL concurrent_gnt: wr=%b%b rd=%b%b expected 10 01",
                     wr_gnt_1, wr_gnt_0, rd_gnt_1, rd_gnt_0);
        end
        tests_run++;
        if (bank_waddr !== 5'd9 || bank_din !== 46'h0ABC || bank_raddr !== 5'd12) begin
            tests_failed++;
            $display("[TB] FAIL concurrent_mux: waddr=%0d din=%h raddr=%0d expected 9 abc 12",
                     bank_waddr, bank_din, bank_raddr);
        end
        @(negedge clk);
        wr_req_1 = 0; rd_req_0 = 0;
        #1;
        tests_run++;
        if (bank_wen !== 1'b0 || bank_waddr !== 5'd1 || bank_din !== 46'h5 || bank_raddr !== 5'd12) begin
            tests_failed++;
            $display("[TB] FAIL idle_mux: wen=%b waddr=%0d din=%h raddr=%0d expected 0 1 5 12",
                     bank_wen, bank_waddr, bank_din, bank_raddr);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        // Leave read pointer at 0 and the NTT side holding the write lock.
        @(negedge clk);
        idle_inputs();
        rd_req_0 = 1; rd_addr_0 = 5'd3;
        wr_req_1 = 1; wr_lock_1 = 1; wr_addr_1 = 5'd30; wr_data_1 = 46'h77;
        // Grant a read in the very cycle reset is sampled.
        @(negedge clk);
        rst = 1;
        #1;
        tests_run++;
        if (rd_gnt_0 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midread_gnt: got %b expected 1", rd_gnt_0);
        end
        @(negedge clk);
        rst = 0;
        rd_req_0 = 1; rd_req_1 = 1;
        wr_req_0 = 1; wr_req_1 = 1; wr_lock_1 = 1;
        #1;
        tests_run++;
        if (rd_valid_0 !== 1'b0 || rd_valid_1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midread_valid: got %b%b expected 00", rd_valid_1, rd_valid_0);
        end
        tests_run++;
        if (rd_gnt_0 !== 1'b1 || rd_gnt_1 !== 1'b0 || wr_gnt_0 !== 1'b1 || wr_gnt_1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_arb: rd=%b%b wr=%b%b expected 01 01",
                     rd_gnt_1, rd_gnt_0, wr_gnt_1, wr_gnt_0);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_single_write_read();
        test_rd_round_robin();
        test_lock_burst();
        test_same_cycle_raw();
        test_concurrent_ports();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/poly_bank_arbiter.md
Name: poly_bank_arbiter

Overview:
- Shares one poly_bank instance (1 write port, 1 read port with registered read address, read data valid one cycle after address) between two requesters: requester 0 = load/store bus side, requester 1 = NTT/arithmetic core.
- Read and write ports are arbitrated independently with round-robin fairness and an optional lock for bursts.
- Returns read data to the owning requester with a one-cycle-delayed valid.
- Sits between the requesters and the bank; no storage of polynomial data itself.

Parameters:
- ADDR_WIDTH, 5, bank address width
- DEPTH, 32, bank depth, passed through to the bank; must equal 2**ADDR_WIDTH
- DATA_WIDTH, 46, coefficient word width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- rd_req_0, rd_req_1  in  1  read request per requester
- rd_lock_0, rd_lock_1  in  1  hold read grant while own rd_req stays high
- rd_addr_0, rd_addr_1  in  ADDR_WIDTH  read address
- rd_gnt_0, rd_gnt_1  out  1  read request accepted this cycle
- rd_valid_0, rd_valid_1  out  1  rd_data valid for that requester
- rd_data  out  DATA_WIDTH  bank read data, shared
- wr_req_0, wr_req_1  in  1  write request
- wr_lock_0, wr_lock_1  in  1  hold write grant
- wr_addr_0, wr_addr_1  in  ADDR_WIDTH  write address
- wr_data_0, wr_data_1  in  DATA_WIDTH  write data
- wr_gnt_0, wr_gnt_1  out  1  write performed at this clock edge
- bank_wen  out  1  to bank wen
- bank_waddr  out  ADDR_WIDTH  to bank waddr
- bank_din  out  DATA_WIDTH  to bank din
- bank_raddr  out  ADDR_WIDTH  to bank raddr
- bank_dout  in  DATA_WIDTH  from bank dout

Behaviour:
- Reset: all registered state cleared.
  - rd_valid_0/1 = 0.
  - Read and write last-grant pointers = 1, so requester 0 wins the first conflict.
  - Read and write lock owners cleared.
  - Grant outputs are combinational: 0 when no request.
- Read and write arbiters are identical, independent instances; each is evaluated every cycle.
- Arbitration (per port), combinational grant:
  - If the lock owner is set and that requester's req is high, it is granted.
  - Else if exactly one req is high, that requester is granted.
  - Else if both reqs are high, the requester not equal to the last-grant pointer is granted.
  - Else no grant.
  - At most one grant per port per cycle; a grant is only asserted with its req.
- Pointer update at a clock edge with a grant: last-grant pointer <= granted id.
- Lock owner update:
  - Set to the granted id if that requester's lock input is high.
  - Cleared when the owner drops req or lock.
  - Lock from a non-granted requester is ignored.
- Write path:
  - bank_wen = wr_gnt_0 | wr_gnt_1.
  - bank_waddr and bank_din are muxed from the granted requester.
  - When no write is granted, these hold requester-0 values with bank_wen = 0.
  - The write lands at the same edge; wr_gnt acts as the ack.
- Read path:
  - bank_raddr is muxed from the granted requester, or rd_addr_0 when idle.
  - rd_valid_x <= rd_gnt_x registered, so rd_valid goes high exactly 1 cycle after grant.
  - rd_data = bank_dout passthrough.
  - Back-to-back grants give one read per cycle, fully pipelined.
- Read and write to the same address in the same cycle: the read returns the NEW data, because the bank is write-first through its registered read address. The arbiter adds no hazard logic.
- Both ports may serve different requesters in the same cycle, e.g. NTT writes while the bus reads.
- Reset mid-operation: an in-flight read's rd_valid is suppressed (forced 0 the cycle after rst). Locks are dropped.
- Starvation bound: an unlocked requester waits at most 1 cycle. A locked requester can starve the other indefinitely; this is by design for NTT bursts.

Decomposition:
- Shared package: requester id constants REQ_BUS = 0 and REQ_NTT = 1, and default widths (ADDR_WIDTH 5, DATA_WIDTH 46).
- One sub-module: rr_lock_arb2, a 2-way round-robin arbiter with lock, pointer and lock-owner registers.
  - Instantiated twice: read and write.
- The datapath muxes and rd_valid pipeline stay in the top module.

Test Plan:
- Reset, then single write: rst 2 cycles; wr_req_0 = 1, addr 3, data 46'h1234 → wr_gnt_0 = 1 and bank_wen = 1 that cycle. Next read from 0 at addr 3 → rd_valid_0 one cycle after grant, rd_data = 46'h1234.
- Read conflict round-robin: rd_req_0 and rd_req_1 both high for 4 cycles → grants alternate 0, 1, 0, 1; rd_valid pattern identical, delayed 1 cycle.
- Lock burst: requester 1 with rd_lock_1 = 1 and rd_req_0 continuously high for 5 cycles → rd_gnt_1 for 5 cycles. After lock drops, rd_gnt_0 is asserted on the next cycle.
- Same-cycle RAW: wr_req_1 addr 7 data 46'h3FFF_FFFF_FFFF, rd_req_0 addr 7 same cycle → next-cycle rd_data = 46'h3FFF_FFFF_FFFF, rd_valid_0 = 1.
- Concurrent ports: wr_req_1 and rd_req_0 only → both granted the same cycle, bank_waddr/bank_din from requester 1, bank_raddr from requester 0.
- Reset mid-read: rd_gnt_0 at cycle N, rst high at edge N+1 → rd_valid_0 = 0 after that edge, pointers back to reset state (requester 0 wins the next conflict).
